// File: rtl/apb_mem_bridge.sv
// APB3 completer bridging single transfers onto the single-beat req/ready memory
// protocol; decodes word addresses and reports misaligned/out-of-range/timeout errors.
module apb_mem_bridge #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int PADDR_W = 16,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [PADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0]  pwdata,
  output logic [DATA_W-1:0]  prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               req_o,
  output logic               req_rnw_o,
  output logic [ADDR_W-1:0]  req_addr_o,
  output logic [DATA_W-1:0]  req_wdata_o,
  input  logic               req_ready_i,
  input  logic [DATA_W-1:0]  req_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             misaligned;
  logic             out_of_range;
  logic             dec_err;

  assign misaligned = |paddr[1:0];

  // Bits above the word address must be zero; a fully-mapped APB space has none.
  generate
    if (PADDR_W > ADDR_W + 2) begin : g_range
      assign out_of_range = |paddr[PADDR_W-1:ADDR_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign dec_err = misaligned | out_of_range;

  // NOTE: every register here is state, so only non-blocking assignments are used;
  // mixing in blocking assignments would make sibling reads order-dependent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      prdata      <= '0;
      pready      <= 1'b0;
      pslverr     <= 1'b0;
      req_o       <= 1'b0;
      req_rnw_o   <= 1'b0;
      req_addr_o  <= '0;
      req_wdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (psel && penable) begin
            if (dec_err) begin
              pready  <= 1'b1;
              pslverr <= 1'b1;
              prdata  <= '0;
              state   <= S_RESP;
            end else begin
              req_rnw_o   <= ~pwrite;
              req_addr_o  <= paddr[ADDR_W+1:2];
              req_wdata_o <= pwdata;
              req_o       <= 1'b1;
              cnt         <= '0;
              state       <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // A handshake on the same cycle as the last timeout count still wins.
          if (req_o && req_ready_i) begin
            prdata  <= req_rnw_o ? req_rdata_i : '0;
            pslverr <= 1'b0;
            pready  <= 1'b1;
            req_o   <= 1'b0;
            state   <= S_RESP;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            prdata  <= '0;
            pslverr <= 1'b1;
            pready  <= 1'b1;
            req_o   <= 1'b0;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RESP: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          cnt     <= '0;
          state   <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Randomised self-checking bench for apb_mem_bridge: a behavioural memory responder
// plus a word-array reference model predicting data, error and latency per transfer.
module tb_apb_mem_bridge;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int PADDR_W = 16;
  localparam int TIMEOUT = 16;
  localparam int WORDS   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              psel, penable, pwrite;
  logic [PADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready, pslverr;
  logic              req_o, req_rnw_o;
  logic [ADDR_W-1:0] req_addr_o;
  logic [DATA_W-1:0] req_wdata_o;
  logic              req_ready_i;
  logic [DATA_W-1:0] req_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  apb_mem_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PADDR_W(PADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .req_o(req_o), .req_rnw_o(req_rnw_o), .req_addr_o(req_addr_o),
    .req_wdata_o(req_wdata_o), .req_ready_i(req_ready_i), .req_rdata_i(req_rdata_i)
  );

  always #5 clk = ~clk;

  // Memory behind the bridge and the reference model of what it should hold.
  logic [DATA_W-1:0] mem     [WORDS];
  logic [DATA_W-1:0] ref_mem [WORDS];
  logic mem_en      = 1'b1;
  logic force_ready = 1'b0;
  int   mem_lat     = 0;

  initial begin
    int wait_cnt;
    wait_cnt    = 0;
    req_ready_i = 1'b0;
    req_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        req_ready_i = force_ready;
        wait_cnt    = 0;
      end else begin
        req_ready_i = 1'b0;
        if (req_o) begin
          if (wait_cnt >= mem_lat) begin
            req_ready_i = 1'b1;
            req_rdata_i = mem[req_addr_o];
            if (!req_rnw_o) mem[req_addr_o] = req_wdata_o;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  function automatic logic exp_err(input logic [PADDR_W-1:0] a);
    return (a % 4 != 0) || (a >= PADDR_W'(4 * WORDS));
  endfunction

  // One complete APB transfer; reports what the bus and memory side showed.
  task automatic apb_xfer(
    input  logic              wr,
    input  logic [PADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              err,
    output int                cyc,
    output int                req_cyc,
    output logic              rnw_seen,
    output logic [ADDR_W-1:0] addr_seen,
    output logic [DATA_W-1:0] wdata_seen,
    output logic              one_cycle
  );
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    cyc = 0; req_cyc = 0; rnw_seen = 1'bx; addr_seen = 'x; wdata_seen = 'x;
    rd = 'x; err = 1'bx;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (req_o) begin
        if (req_cyc == 0) begin
          rnw_seen = req_rnw_o; addr_seen = req_addr_o; wdata_seen = req_wdata_o;
        end
        req_cyc++;
      end
      if (pready) break;
      if (cyc > 200) begin
        n_checks++; n_fail++;
        $display("FAIL xfer_timeout: pready not seen after %0d cycles, required within 200", cyc);
        break;
      end
    end
    rd  = prdata;
    err = pslverr;
    @(posedge clk);
    #1;
    one_cycle = (pready === 1'b0);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({prdata, pready, pslverr, req_o, req_rnw_o, req_addr_o, req_wdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: prdata=%h pready=%b pslverr=%b req_o=%b rnw=%b addr=%h wdata=%h, required all 0",
               prdata, pready, pslverr, req_o, req_rnw_o, req_addr_o, req_wdata_o);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] rd, wds; logic err, rnw, oc; int cyc, rc; logic [ADDR_W-1:0] a;
    mem_lat = 0;
    apb_xfer(1'b1, 16'h0010, 32'hDEADBEEF, rd, err, cyc, rc, rnw, a, wds, oc);
    ref_mem[4] = 32'hDEADBEEF;
    n_checks++;
    if ({rnw, a, wds} !== {1'b0, 10'd4, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL write_req_fields: rnw=%b addr=%0d wdata=%h, required 0/4/deadbeef", rnw, a, wds);
    end
    n_checks++;
    if (cyc !== 2 || err !== 1'b0 || rc !== 1) begin
      n_fail++; $display("FAIL write_latency: cyc=%0d err=%b req_cyc=%0d, required 2/0/1", cyc, err, rc);
    end
    n_checks++;
    if (oc !== 1'b1) begin
      n_fail++; $display("FAIL pready_one_cycle: pready still high after response cycle, required low");
    end
    apb_xfer(1'b0, 16'h0010, 32'h0, rd, err, cyc, rc, rnw, a, wds, oc);
    n_checks++;
    if (rnw !== 1'b1 || a !== 10'd4) begin
      n_fail++; $display("FAIL read_req_fields: rnw=%b addr=%0d, required 1/4", rnw, a);
    end
    n_checks++;
    if (rd !== ref_mem[4] || err !== 1'b0 || cyc !== 2) begin
      n_fail++; $display("FAIL read_data: prdata=%h err=%b cyc=%0d, required %h/0/2", rd, err, cyc, ref_mem[4]);
    end
  endtask

  task automatic test_decode_errors();
    logic [DATA_W-1:0] rd, wds; logic err, rnw, oc; int cyc, rc; logic [ADDR_W-1:0] a;
    apb_xfer(1'b0, 16'h0012, 32'h0, rd, err, cyc, rc, rnw, a, wds, oc);
    n_checks++;
    if (rc !== 0 || cyc !== 1 || err !== 1'b1 || rd !== '0) begin
      n_fail++; $display("FAIL misaligned: req_cyc=%0d cyc=%0d err=%b prdata=%h, required 0/1/1/0", rc, cyc, err, rd);
    end
    apb_xfer(1'b1, 16'h1000, 32'h12345678, rd, err, cyc, rc, rnw, a, wds, oc);
    n_checks++;
    if (rc !== 0 || cyc !== 1 || err !== 1'b1 || oc !== 1'b1) begin
      n_fail++; $display("FAIL out_of_range: req_cyc=%0d cyc=%0d err=%b one_cycle=%b, required 0/1/1/1", rc, cyc, err, oc);
    end
    // Out-of-range alias of word 0 must not have been written.
    apb_xfer(1'b0, 16'h0000, 32'h0, rd, err, cyc, rc, rnw, a, wds, oc);
    n_checks++;
    if (rd !== ref_mem[0] || err !== 1'b0) begin
      n_fail++; $display("FAIL no_alias_write: prdata=%h err=%b, required %h/0", rd, err, ref_mem[0]);
    end
  endtask

  task automatic test_timeout();
    logic [DATA_W-1:0] rd, wds; logic err, rnw, oc; int cyc, rc; logic [ADDR_W-1:0] a;
    mem_en = 1'b0;
    apb_xfer(1'b1, 16'h0020, 32'hCAFEF00D, rd, err, cyc, rc, rnw, a, wds, oc);
    n_checks++;
    if (rc !== TIMEOUT || cyc !== TIMEOUT + 1 || err !== 1'b1 || rd !== '0) begin
      n_fail++; $display("FAIL timeout: req_cyc=%0d cyc=%0d err=%b prdata=%h, required %0d/%0d/1/0",
                         rc, cyc, err, rd, TIMEOUT, TIMEOUT + 1);
    end
    force_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (req_o !== 1'b0 || pready !== 1'b0) begin
        n_fail++; $display("FAIL late_ready: req_o=%b pready=%b, required 0/0", req_o, pready);
      end
    end
    force_ready = 1'b0;
    mem_en = 1'b1;
    apb_xfer(1'b0, 16'h0020, 32'h0, rd, err, cyc, rc, rnw, a, wds, oc);
    n_checks++;
    if (rd !== ref_mem[8] || err !== 1'b0 || cyc !== 2) begin
      n_fail++; $display("FAIL after_timeout_read: prdata=%h err=%b cyc=%0d, required %h/0/2", rd, err, cyc, ref_mem[8]);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] rd, wds; logic err, rnw, oc; int cyc, rc; logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] idx [10];
    int lat;
    for (int i = 0; i < 10; i++) begin
      logic [DATA_W-1:0] d;
      idx[i] = ADDR_W'($urandom_range(0, WORDS - 1));
      d = $urandom;
      lat = $urandom_range(0, 3);
      mem_lat = lat;
      apb_xfer(1'b1, PADDR_W'(idx[i]) * 4, d, rd, err, cyc, rc, rnw, a, wds, oc);
      ref_mem[idx[i]] = d;
      n_checks++;
      if (err !== 1'b0 || cyc !== lat + 2 || a !== idx[i] || wds !== d) begin
        n_fail++; $display("FAIL rand_write[%0d]: err=%b cyc=%0d addr=%0d wdata=%h, required 0/%0d/%0d/%h",
                           i, err, cyc, a, wds, lat + 2, idx[i], d);
      end
    end
    for (int i = 0; i < 10; i++) begin
      lat = $urandom_range(0, 3);
      mem_lat = lat;
      apb_xfer(1'b0, PADDR_W'(idx[i]) * 4, 32'h0, rd, err, cyc, rc, rnw, a, wds, oc);
      n_checks++;
      if (rd !== ref_mem[idx[i]] || err !== 1'b0 || cyc !== lat + 2) begin
        n_fail++; $display("FAIL rand_read[%0d]: prdata=%h err=%b cyc=%0d, required %h/0/%0d",
                           i, rd, err, cyc, ref_mem[idx[i]], lat + 2);
      end
    end
    // Mixed traffic at arbitrary byte addresses, errors predicted from the address alone.
    for (int i = 0; i < 16; i++) begin
      logic [PADDR_W-1:0] pa; logic w, e; logic [DATA_W-1:0] d;
      pa = ($urandom_range(0, 1) == 1) ? PADDR_W'($urandom_range(0, 16'hFFFF))
                                       : PADDR_W'($urandom_range(0, 4 * WORDS - 1));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      e = exp_err(pa);
      mem_lat = 0;
      apb_xfer(w, pa, d, rd, err, cyc, rc, rnw, a, wds, oc);
      if (!e && w) ref_mem[pa / 4] = d;
      n_checks++;
      if (err !== e || cyc !== (e ? 1 : 2) || rc !== (e ? 0 : 1) ||
          (!w && rd !== (e ? '0 : ref_mem[pa / 4]))) begin
        n_fail++; $display("FAIL rand_mixed[%0d] addr=%h wr=%b: err=%b cyc=%0d req_cyc=%0d prdata=%h, required err=%b",
                           i, pa, w, err, cyc, rc, rd, e);
      end
    end
  endtask

  task automatic test_reset_in_req();
    logic [DATA_W-1:0] rd, wds; logic err, rnw, oc; int cyc, rc; logic [ADDR_W-1:0] a;
    mem_en = 1'b0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0044; pwdata = 32'hA5A5A5A5;
    @(negedge clk);
    penable = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_setup: req_o=%b, required 1", req_o);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({prdata, pready, pslverr, req_o, req_rnw_o, req_addr_o, req_wdata_o} !== '0) begin
      n_fail++; $display("FAIL reset_in_req: req_o=%b pready=%b addr=%h wdata=%h, required all 0",
                         req_o, pready, req_addr_o, req_wdata_o);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mem_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (pready !== 1'b0 || req_o !== 1'b0) begin
        n_fail++; $display("FAIL abandoned_xfer: pready=%b req_o=%b, required 0/0", pready, req_o);
      end
    end
    apb_xfer(1'b0, 16'h0044, 32'h0, rd, err, cyc, rc, rnw, a, wds, oc);
    n_checks++;
    if (rd !== ref_mem[17] || err !== 1'b0 || cyc !== 2) begin
      n_fail++; $display("FAIL post_reset_read: prdata=%h err=%b cyc=%0d, required %h/0/2", rd, err, cyc, ref_mem[17]);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_write_read();
    test_decode_errors();
    test_timeout();
    test_random();
    test_reset_in_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
